// File: rtl/phist_ckpt_ctrl_pkg.sv
// Shared types for the TAGE path-history checkpoint controller.
package tage_pkg;
  localparam int PHIST_LEN_DEFAULT = 16;
  typedef logic [PHIST_LEN_DEFAULT-1:0] phist_t;
  typedef enum logic {IDLE, RECOVER} ckpt_state_e;
endpackage

// File: rtl/phist_ckpt_ctrl_if.sv
// Fetch / branch-resolve side of the path-history controller.
interface phist_ckpt_ctrl_if #(
  parameter int CKPT_DEPTH = 8
);
  localparam int TAG_W = $clog2(CKPT_DEPTH);

  logic             pred_valid;
  logic [31:0]      pred_pc;
  logic             pred_ready;
  logic [TAG_W-1:0] pred_tag;
  logic             commit_valid;
  logic             flush_valid;
  logic [TAG_W-1:0] flush_tag;
  logic             flush_all;

  modport master (
    output pred_valid, pred_pc, commit_valid, flush_valid, flush_tag, flush_all,
    input  pred_ready, pred_tag
  );
  modport slave (
    input  pred_valid, pred_pc, commit_valid, flush_valid, flush_tag, flush_all,
    output pred_ready, pred_tag
  );
endinterface

// File: rtl/phist_ckpt_ctrl_ram.sv
// Checkpoint store: one write port (push), two async read ports (head, flush tag).
module phist_ckpt_ram #(
  parameter int  PHIST_LEN  = 16,
  parameter int  CKPT_DEPTH = 8,
  localparam int TAG_W      = $clog2(CKPT_DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [TAG_W-1:0]     waddr,
  input  logic [PHIST_LEN-1:0] wdata,
  input  logic [TAG_W-1:0]     raddr_head,
  output logic [PHIST_LEN-1:0] rdata_head,
  input  logic [TAG_W-1:0]     raddr_flush,
  output logic [PHIST_LEN-1:0] rdata_flush
);
  logic [CKPT_DEPTH-1:0][PHIST_LEN-1:0] mem;

  // No reset: entries are only read inside the valid [head,tail) window.
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata_head  = mem[raddr_head];
  assign rdata_flush = mem[raddr_flush];
endmodule

// File: rtl/phist_ckpt_ctrl.sv
// Speculative/architectural path-history controller with per-branch checkpoints.
// Optional PHIST_CKPT_PERF_EN adds saturating push/flush/full-stall counters.
module phist_ckpt_ctrl
  import tage_pkg::*;
#(
  parameter int  PHIST_LEN  = PHIST_LEN_DEFAULT,
  parameter int  CKPT_DEPTH = 8,
  localparam int TAG_W      = $clog2(CKPT_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  phist_ckpt_ctrl_if.slave     bus,
  output logic [PHIST_LEN-1:0] spec_phist,
  output logic [PHIST_LEN-1:0] arch_phist,
  output logic [TAG_W:0]       ckpt_count,
  output logic                 busy
`ifdef PHIST_CKPT_PERF_EN
  ,
  output logic [31:0]          perf_push,
  output logic [31:0]          perf_flush,
  output logic [31:0]          perf_full_stall
`endif
);
  ckpt_state_e          state, state_nxt;
  logic [TAG_W:0]       head, tail, count, head_nxt, tail_flush;
  logic [TAG_W-1:0]     flush_off;
  logic                 full, ready, push, do_commit, flush_hit, any_flush;
  logic [PHIST_LEN-1:0] push_hist, rd_head, rd_flush, arch_nxt;
  logic                 unused_pc;

  assign unused_pc  = ^{bus.pred_pc[31:3], bus.pred_pc[1:0]};
  assign count      = tail - head;
  assign full       = (count == (TAG_W+1)'(CKPT_DEPTH));
  assign any_flush  = bus.flush_valid | bus.flush_all;
  assign push       = bus.pred_valid & ready;
  assign do_commit  = bus.commit_valid & (count != '0);
  // Offset from head tells whether flush_tag lies in the in-flight window.
  assign flush_off  = bus.flush_tag - head[TAG_W-1:0];
  assign flush_hit  = bus.flush_valid & ({1'b0, flush_off} < count);
  assign tail_flush = head + {1'b0, flush_off} + (TAG_W+1)'(1);
  assign push_hist  = {spec_phist[PHIST_LEN-2:0], bus.pred_pc[2]};
  assign head_nxt   = head + (TAG_W+1)'(do_commit);
  assign arch_nxt   = do_commit ? rd_head : arch_phist;

  assign bus.pred_ready = ready;
  assign bus.pred_tag   = tail[TAG_W-1:0];
  assign ckpt_count     = count;
  assign busy           = (state == RECOVER);

  phist_ckpt_ram #(.PHIST_LEN(PHIST_LEN), .CKPT_DEPTH(CKPT_DEPTH)) u_ram (
    .clk         (clk),
    .we          (push),
    .waddr       (tail[TAG_W-1:0]),
    .wdata       (push_hist),
    .raddr_head  (head[TAG_W-1:0]),
    .rdata_head  (rd_head),
    .raddr_flush (bus.flush_tag),
    .rdata_flush (rd_flush)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        ready = ~full & ~any_flush;
        if (any_flush) state_nxt = RECOVER;
      end
      RECOVER: state_nxt = any_flush ? RECOVER : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // flush_all restores from the post-commit architectural state.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head       <= '0;
      tail       <= '0;
      spec_phist <= '0;
      arch_phist <= '0;
    end else begin
      head       <= head_nxt;
      arch_phist <= arch_nxt;
      if (bus.flush_all) begin
        spec_phist <= arch_nxt;
        tail       <= head_nxt;
      end else if (flush_hit) begin
        spec_phist <= rd_flush;
        tail       <= tail_flush;
      end else if (push) begin
        spec_phist <= push_hist;
        tail       <= tail + (TAG_W+1)'(1);
      end
    end

`ifdef PHIST_CKPT_PERF_EN
  logic [32:0] flush_sum;
  assign flush_sum = {1'b0, perf_flush} + 33'({1'b0, bus.flush_valid} + {1'b0, bus.flush_all});

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_push       <= '0;
      perf_flush      <= '0;
      perf_full_stall <= '0;
    end else begin
      if (push && perf_push != '1) perf_push <= perf_push + 32'd1;
      perf_flush <= flush_sum[32] ? '1 : flush_sum[31:0];
      if (bus.pred_valid && full && perf_full_stall != '1)
        perf_full_stall <= perf_full_stall + 32'd1;
    end
`endif
endmodule

// File: tb/tb_phist_ckpt_ctrl.sv
// Random + directed bench for phist_ckpt_ctrl against a queue-based history model.
module tb_phist_ckpt_ctrl;
  import tage_pkg::*;
  localparam int D     = 8;
  localparam int TAG_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [15:0]      spec_phist, arch_phist;
  logic [TAG_W:0]   ckpt_count;
  logic             busy;
`ifdef PHIST_CKPT_PERF_EN
  logic [31:0]      perf_push, perf_flush, perf_full_stall;
`endif

  phist_ckpt_ctrl_if #(.CKPT_DEPTH(D)) bus ();

  phist_ckpt_ctrl #(.PHIST_LEN(16), .CKPT_DEPTH(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .spec_phist (spec_phist),
    .arch_phist (arch_phist),
    .ckpt_count (ckpt_count),
    .busy       (busy)
`ifdef PHIST_CKPT_PERF_EN
    ,
    .perf_push       (perf_push),
    .perf_flush      (perf_flush),
    .perf_full_stall (perf_full_stall)
`endif
  );

  always #5 clk = ~clk;

  // Model: in-flight branches as an ordered list of (tag, checkpointed history).
  typedef struct { int tag; phist_t val; } ent_t;
  ent_t   q[$];
  int     hseq;
  phist_t m_spec, m_arch;
  bit     m_rec;

  int ncmp = 0, nerr = 0;
  logic [TAG_W-1:0] got_tag;
  logic             got_ready;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    ncmp++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic model_reset();
    q.delete();
    hseq = 0; m_spec = '0; m_arch = '0; m_rec = 1'b0;
  endtask

  function automatic bit model_ready(input bit fv, input bit fa);
    return !m_rec && q.size() < D && !fv && !fa;
  endfunction

  task automatic model_update(input bit pv, input logic [31:0] pc, input bit cv,
                              input bit fv, input logic [TAG_W-1:0] ftag, input bit fa);
    bit     rdy, cm;
    phist_t arch_new;
    int     idx;
    rdy = model_ready(fv, fa);
    cm  = cv && q.size() > 0;
    arch_new = cm ? q[0].val : m_arch;
    if (fa) begin
      q.delete();
      if (cm) hseq++;
      m_spec = arch_new;
    end else begin
      if (fv) begin
        idx = -1;
        foreach (q[i]) if (q[i].tag == int'(ftag)) idx = i;
        if (idx >= 0) begin
          m_spec = q[idx].val;
          while (q.size() > idx + 1) void'(q.pop_back());
        end
      end else if (pv && rdy) begin
        ent_t e;
        m_spec = {m_spec[14:0], pc[2]};
        e.tag = (hseq + q.size()) % D;
        e.val = m_spec;
        q.push_back(e);
      end
      if (cm) begin
        void'(q.pop_front());
        hseq++;
      end
    end
    m_arch = arch_new;
    m_rec  = fv || fa;
  endtask

  task automatic compare_model();
    chk("spec_phist", 32'(spec_phist), 32'(m_spec));
    chk("arch_phist", 32'(arch_phist), 32'(m_arch));
    chk("ckpt_count", 32'(ckpt_count), q.size());
    chk("busy", 32'(busy), 32'(m_rec));
  endtask

  // Entered at a negedge; returns at the next negedge with outputs compared.
  task automatic step(input bit pv, input logic [31:0] pc, input bit cv,
                      input bit fv, input logic [TAG_W-1:0] ftag, input bit fa);
    bit er;
    bus.pred_valid = pv; bus.pred_pc = pc; bus.commit_valid = cv;
    bus.flush_valid = fv; bus.flush_tag = ftag; bus.flush_all = fa;
    #1;
    er = model_ready(fv, fa);
    got_ready = bus.pred_ready;
    got_tag   = bus.pred_tag;
    chk("pred_ready", 32'(got_ready), 32'(er));
    if (pv && er) chk("pred_tag", 32'(got_tag), (hseq + q.size()) % D);
    @(posedge clk);
    model_update(pv, pc, cv, fv, ftag, fa);
    @(negedge clk);
    bus.pred_valid = 1'b0; bus.pred_pc = '0; bus.commit_valid = 1'b0;
    bus.flush_valid = 1'b0; bus.flush_tag = '0; bus.flush_all = 1'b0;
    compare_model();
  endtask

  task automatic push(input logic [31:0] pc); step(1, pc, 0, 0, '0, 0); endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.pred_valid = 1'b0; bus.pred_pc = '0; bus.commit_valid = 1'b0;
    bus.flush_valid = 1'b0; bus.flush_tag = '0; bus.flush_all = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1 compare_model();
    chk("reset pred_ready", 32'(bus.pred_ready), 1);
  endtask

  task automatic t1_pushes();
    push(32'h4); chk("t1 tag0", 32'(got_tag), 0);
    push(32'h0); chk("t1 tag1", 32'(got_tag), 1);
    push(32'h4); chk("t1 tag2", 32'(got_tag), 2);
  endtask

  initial begin
    bus.pred_valid = 1'b0; bus.pred_pc = '0; bus.commit_valid = 1'b0;
    bus.flush_valid = 1'b0; bus.flush_tag = '0; bus.flush_all = 1'b0;
    model_reset();

    // Reset values and three pushes
    do_reset();
    chk("reset spec", 32'(spec_phist), 0);
    chk("reset count", 32'(ckpt_count), 0);
    t1_pushes();
    chk("t1 spec", 32'(spec_phist), 32'h5);
    chk("t1 count", 32'(ckpt_count), 3);

    // Flush at tag 0 keeps branch 0 in flight
    step(0, '0, 0, 1, 3'd0, 0);
    chk("t3 spec", 32'(spec_phist), 32'h1);
    chk("t3 count", 32'(ckpt_count), 1);
    chk("t3 busy", 32'(busy), 1);
    step(0, '0, 0, 0, '0, 0);
    chk("t3 busy clr", 32'(busy), 0);
    push(32'h0);
    chk("t3 next tag", 32'(got_tag), 1);

    // In-order commits, commit on empty ignored
    do_reset();
    t1_pushes();
    step(0, '0, 1, 0, '0, 0); chk("t4 arch1", 32'(arch_phist), 32'h1);
    step(0, '0, 1, 0, '0, 0); chk("t4 arch2", 32'(arch_phist), 32'h2);
    step(0, '0, 1, 0, '0, 0); chk("t4 arch3", 32'(arch_phist), 32'h5);
    step(0, '0, 1, 0, '0, 0); chk("t4 arch empty", 32'(arch_phist), 32'h5);
    chk("t4 count", 32'(ckpt_count), 0);

    // Full stall, then a commit frees a slot
    do_reset();
    for (int i = 0; i < D; i++) push(32'($urandom));
    chk("t2 count", 32'(ckpt_count), 8);
    step(1, 32'h4, 1, 0, '0, 0);
    chk("t2 full ready", 32'(got_ready), 0);
    step(1, 32'h4, 0, 0, '0, 0);
    chk("t2 ready", 32'(got_ready), 1);
    chk("t2 wrap tag", 32'(got_tag), 0);

    // Push + commit + flush_all together
    do_reset();
    t1_pushes();
    step(0, '0, 1, 0, '0, 0);
    step(1, 32'h4, 1, 0, '0, 1);
    chk("t5 ready", 32'(got_ready), 0);
    chk("t5 spec", 32'(spec_phist), 32'h2);
    chk("t5 arch", 32'(arch_phist), 32'h2);
    chk("t5 count", 32'(ckpt_count), 0);

    // Async reset while recovering
    do_reset();
    t1_pushes();
    step(0, '0, 0, 1, 3'd1, 0);
    chk("t6 busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("t6 spec", 32'(spec_phist), 0);
    chk("t6 arch", 32'(arch_phist), 0);
    chk("t6 count", 32'(ckpt_count), 0);
    chk("t6 busy rst", 32'(busy), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("t6 ready", 32'(bus.pred_ready), 1);
    compare_model();

    // Random traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit pv, cv, fv, fa;
      pv = ($urandom_range(0, 9) < 7);
      cv = ($urandom_range(0, 9) < 3);
      fv = ($urandom_range(0, 99) < 8);
      fa = ($urandom_range(0, 99) < 3);
      step(pv, 32'($urandom), cv, fv, 3'($urandom), fa);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
